// File: rtl/uart_slave_if.sv
// rtl/uart_slave_if.sv - shared-bus slave port signals for the UART peripheral
interface uart_slave_if;
   logic        CS_;
   logic        As_;
   logic        RW;
   logic [29:0] Addr;
   logic [31:0] WrData;
   logic [31:0] RdData;
   logic        Rdy_;

   modport master (
      output CS_, As_, RW, Addr, WrData,
      input  RdData, Rdy_
   );

   modport slave (
      input  CS_, As_, RW, Addr, WrData,
      output RdData, Rdy_
   );
endinterface

// File: rtl/uart_slave.sv
// rtl/uart_slave.sv - memory-mapped 8N1 UART with STATUS/DATA registers and level interrupts
module uart_slave #(
   parameter int DIV_CNT = 260,
   parameter int DIV_W   = 9
) (
   input  logic        clk,
   input  logic        reset_,
   uart_slave_if.slave bus,
   output logic        RxIrq,
   output logic        TxIrq,
   input  logic        UartRX,
   output logic        UartTX
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_CNT - 1);
   localparam logic [DIV_W-1:0] HALF = DIV_W'(DIV_CNT / 2);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rxState_t;

   txState_t         txState, txStateNext;
   rxState_t         rxState, rxStateNext;
   logic [DIV_W-1:0] txCnt, rxCnt;
   logic [2:0]       txBitIdx, rxBitIdx;
   logic [7:0]       txShift, rxShift, rxData;
   logic             txTick, txStart, txDone, txLevel;
   logic             rxHalf, rxSample, rxGood, rxBad;
   logic             rxMeta, rxS;
   logic             rxIntr, txIntr, frameErr, overrun;
   logic             rxBusy, txBusy;
   logic             accept, wrStatus, wrDataReg;
   logic [31:0]      statusWord, rdMux;
   logic             unusedBits;

   assign accept    = !bus.CS_ && !bus.As_;
   assign wrStatus  = accept && !bus.RW && !bus.Addr[0];
   assign wrDataReg = accept && !bus.RW &&  bus.Addr[0];

   assign txBusy = (txState != TX_IDLE);
   assign rxBusy = (rxState != RX_IDLE);

   assign statusWord = {26'b0, overrun, frameErr, txBusy, rxBusy, txIntr, rxIntr};
   assign rdMux      = bus.Addr[0] ? {24'b0, rxData} : statusWord;

   assign RxIrq = rxIntr;
   assign TxIrq = txIntr;

   assign unusedBits = &{1'b0, bus.Addr[29:1], bus.WrData[31:8]};

   // Bus response: one-cycle Rdy_ pulse after every accepted access, read data only in that cycle
   always_ff @(posedge clk) begin
      if (!reset_) begin
         bus.Rdy_   <= 1'b1;
         bus.RdData <= 32'b0;
      end else begin
         bus.Rdy_   <= !accept;
         bus.RdData <= (accept && bus.RW) ? rdMux : 32'b0;
      end
   end

   // STATUS flags: software writes load rw0 bits, hardware sets on the same edge take priority
   always_ff @(posedge clk) begin
      if (!reset_) begin
         rxIntr   <= 1'b0;
         txIntr   <= 1'b0;
         frameErr <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rxIntr   <= rxGood | (wrStatus ? bus.WrData[0] : rxIntr);
         txIntr   <= txDone | (wrStatus ? bus.WrData[1] : txIntr);
         frameErr <= rxBad  | (wrStatus ? bus.WrData[4] : frameErr);
         overrun  <= (rxGood && rxIntr) | (wrStatus ? bus.WrData[5] : overrun);
      end
   end

   // TX next-state and line level for the current state
   always_comb begin
      txStateNext = txState;
      txTick      = (txState != TX_IDLE) && (txCnt == LAST);
      txStart     = 1'b0;
      txDone      = 1'b0;
      txLevel     = 1'b1;
      case (txState)
         TX_IDLE: begin
            if (wrDataReg) begin
               txStart     = 1'b1;
               txStateNext = TX_START;
            end
         end
         TX_START: begin
            txLevel = 1'b0;
            if (txTick) txStateNext = TX_DATA;
         end
         TX_DATA: begin
            txLevel = txShift[txBitIdx];
            if (txTick && txBitIdx == 3'd7) txStateNext = TX_STOP;
         end
         TX_STOP: begin
            if (txTick) begin
               txDone      = 1'b1;
               txStateNext = TX_IDLE;
            end
         end
         default: txStateNext = TX_IDLE;
      endcase
   end

   // TX state register, bit timer, byte latch and registered serial output
   always_ff @(posedge clk) begin
      if (!reset_) begin
         txState  <= TX_IDLE;
         txCnt    <= '0;
         txBitIdx <= 3'd0;
         txShift  <= 8'd0;
         UartTX   <= 1'b1;
      end else begin
         txState <= txStateNext;
         txCnt   <= (txState == TX_IDLE || txTick) ? '0 : txCnt + DIV_W'(1);
         if (txStart) txShift <= bus.WrData[7:0];
         if (txState == TX_DATA && txTick) txBitIdx <= txBitIdx + 3'd1;
         UartTX <= txLevel;
      end
   end

   // RX next-state: start qualification at mid-bit, centre sampling, stop check, break hold-off
   always_comb begin
      rxStateNext = rxState;
      rxHalf      = (rxState == RX_START) && (rxCnt == HALF);
      rxSample    = (rxState == RX_DATA || rxState == RX_STOP) && (rxCnt == LAST);
      rxGood      = 1'b0;
      rxBad       = 1'b0;
      case (rxState)
         RX_IDLE: begin
            if (!rxS) rxStateNext = RX_START;
         end
         RX_START: begin
            if (rxHalf) rxStateNext = rxS ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (rxSample && rxBitIdx == 3'd7) rxStateNext = RX_STOP;
         end
         RX_STOP: begin
            if (rxSample) begin
               if (rxS) begin
                  rxGood      = 1'b1;
                  rxStateNext = RX_IDLE;
               end else begin
                  rxBad       = 1'b1;
                  rxStateNext = RX_WAIT_HIGH;
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (rxS) rxStateNext = RX_IDLE;
         end
         default: rxStateNext = RX_IDLE;
      endcase
   end

   // RX synchronizer, state register, bit timer, shift register and received byte
   always_ff @(posedge clk) begin
      if (!reset_) begin
         rxMeta   <= 1'b1;
         rxS      <= 1'b1;
         rxState  <= RX_IDLE;
         rxCnt    <= '0;
         rxBitIdx <= 3'd0;
         rxShift  <= 8'd0;
         rxData   <= 8'd0;
      end else begin
         rxMeta  <= UartRX;
         rxS     <= rxMeta;
         rxState <= rxStateNext;
         if (rxState == RX_IDLE || rxState == RX_WAIT_HIGH || rxHalf || rxSample)
            rxCnt <= '0;
         else
            rxCnt <= rxCnt + DIV_W'(1);
         if (rxState == RX_DATA && rxSample) begin
            rxShift  <= {rxS, rxShift[7:1]};
            rxBitIdx <= rxBitIdx + 3'd1;
         end
         if (rxGood) rxData <= rxShift;
      end
   end

endmodule

// File: tb/tb_uart_slave.sv
// tb/tb_uart_slave.sv - directed self-checking bench for uart_slave
module tb_uart_slave;
   logic clk = 1'b0;
   logic reset_;
   logic RxIrq, TxIrq, UartTX;
   logic rxDrv, loopOn;
   logic rxLine;
   int   checks = 0;
   int   errors = 0;

   uart_slave_if bus();

   assign rxLine = loopOn ? UartTX : rxDrv;

   uart_slave #(.DIV_CNT(4), .DIV_W(4)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus.slave),
      .RxIrq  (RxIrq),
      .TxIrq  (TxIrq),
      .UartRX (rxLine),
      .UartTX (UartTX)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic busXfer(input logic rw, input logic a0, input logic [31:0] wd,
                          output logic [31:0] rd, output logic rdy);
      bus.CS_    = 1'b0;
      bus.As_    = 1'b0;
      bus.RW     = rw;
      bus.Addr   = {29'b0, a0};
      bus.WrData = wd;
      @(posedge clk);
      #1;
      rd  = bus.RdData;
      rdy = bus.Rdy_;
      bus.CS_    = 1'b1;
      bus.As_    = 1'b1;
      bus.RW     = 1'b1;
      bus.WrData = 32'b0;
   endtask

   task automatic regWrite(input string tag, input logic a0, input logic [31:0] wd);
      logic [31:0] rd;
      logic        rdy;
      busXfer(1'b0, a0, wd, rd, rdy);
      check({tag, " rdy"}, {31'b0, rdy}, 32'd0);
      check({tag, " rddata"}, rd, 32'd0);
   endtask

   task automatic regRead(input string tag, input logic a0, input logic [31:0] exp);
      logic [31:0] rd;
      logic        rdy;
      busXfer(1'b1, a0, 32'b0, rd, rdy);
      check({tag, " rdy"}, {31'b0, rdy}, 32'd0);
      check(tag, rd, exp);
      check({tag, " rdy release"}, {31'b0, bus.Rdy_}, 32'd0 | 32'd0 + {31'b0, 1'b0});
   endtask

   // Samples 40 cycles starting right after the accepting edge; compares against an 8N1 frame
   task automatic txCapture(input logic [7:0] expByte, output logic [7:0] got, output int bad);
      logic s, e;
      int   slot;
      got = 8'h00;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         s    = UartTX;
         slot = i / 4;
         if (slot == 0)      e = 1'b0;
         else if (slot == 9) e = 1'b1;
         else                e = expByte[slot-1];
         if (s !== e) bad++;
         if ((i % 4) == 1 && slot >= 1 && slot <= 8) got[slot-1] = s;
      end
   endtask

   task automatic sendRx(input logic [7:0] b, input logic stopLvl, input int stopCyc);
      rxDrv = 1'b0;
      tick(4);
      for (int k = 0; k < 8; k++) begin
         rxDrv = b[k];
         tick(4);
      end
      rxDrv = stopLvl;
      tick(stopCyc);
   endtask

   initial begin
      logic [7:0]  got;
      logic [31:0] rd;
      logic        rdy;
      int          bad;
      int          lows;

      reset_     = 1'b0;
      rxDrv      = 1'b1;
      loopOn     = 1'b0;
      bus.CS_    = 1'b1;
      bus.As_    = 1'b1;
      bus.RW     = 1'b1;
      bus.Addr   = 30'b0;
      bus.WrData = 32'b0;
      tick(3);

      check("reset uarttx", {31'b0, UartTX}, 32'd1);
      check("reset rdy", {31'b0, bus.Rdy_}, 32'd1);
      check("reset rddata", bus.RdData, 32'd0);
      check("reset irqs", {30'b0, RxIrq, TxIrq}, 32'd0);
      reset_ = 1'b1;
      tick(1);
      regRead("reset status", 1'b0, 32'h00);
      regRead("reset rxdata", 1'b1, 32'h00);

      // Reset in the middle of a transmit frame
      regWrite("midframe write", 1'b1, 32'h00);
      tick(10);
      check("midframe tx low", {31'b0, UartTX}, 32'd0);
      reset_ = 1'b0;
      tick(3);
      check("midreset uarttx", {31'b0, UartTX}, 32'd1);
      check("midreset rdy", {31'b0, bus.Rdy_}, 32'd1);
      check("midreset rddata", bus.RdData, 32'd0);
      reset_ = 1'b1;
      tick(1);
      regRead("midreset status", 1'b0, 32'h00);
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (UartTX !== 1'b1) lows++;
      end
      check("no tx restart", lows, 0);

      // Transmit 0xA5
      regWrite("tx a5 write", 1'b1, 32'h0000_00A5);
      txCapture(8'hA5, got, bad);
      check("tx a5 frame bits", bad, 0);
      check("tx a5 byte", {24'b0, got}, 32'hA5);
      check("tx a5 txirq", {31'b0, TxIrq}, 32'd1);
      regRead("tx a5 status", 1'b0, 32'h02);
      regWrite("tx clear", 1'b0, 32'h0);
      check("tx cleared txirq", {31'b0, TxIrq}, 32'd0);
      regRead("tx cleared status", 1'b0, 32'h00);

      // Write to DATA while busy is ignored
      regWrite("busy first write", 1'b1, 32'h3C);
      fork
         txCapture(8'h3C, got, bad);
         begin
            tick(6);
            busXfer(1'b0, 1'b1, 32'hFF, rd, rdy);
         end
      join
      check("busy frame bits", bad, 0);
      check("busy byte", {24'b0, got}, 32'h3C);
      check("busy second rdy", {31'b0, rdy}, 32'd0);
      tick(2);
      check("busy line idle", {31'b0, UartTX}, 32'd1);
      regRead("busy status", 1'b0, 32'h02);
      regWrite("busy clear", 1'b0, 32'h0);

      // Receive 0x5A, then 0x11 without clearing -> overrun
      sendRx(8'h5A, 1'b1, 4);
      tick(4);
      check("rx 5a rxirq", {31'b0, RxIrq}, 32'd1);
      regRead("rx 5a data", 1'b1, 32'h5A);
      regRead("rx 5a status", 1'b0, 32'h01);
      sendRx(8'h11, 1'b1, 4);
      tick(4);
      regRead("rx overrun status", 1'b0, 32'h21);
      regRead("rx 11 data", 1'b1, 32'h11);
      regWrite("rx clear", 1'b0, 32'h0);
      regRead("rx cleared status", 1'b0, 32'h00);

      // One-cycle low glitch
      rxDrv = 1'b0;
      tick(1);
      rxDrv = 1'b1;
      tick(12);
      regRead("glitch status", 1'b0, 32'h00);
      check("glitch rxirq", {31'b0, RxIrq}, 32'd0);

      // Frame error with a 20-cycle low stop bit
      sendRx(8'h33, 1'b0, 20);
      regRead("framing held status", 1'b0, 32'h14);
      rxDrv = 1'b1;
      tick(8);
      regRead("framing release status", 1'b0, 32'h10);
      regRead("framing data kept", 1'b1, 32'h11);
      check("framing rxirq", {31'b0, RxIrq}, 32'd0);
      regWrite("framing clear", 1'b0, 32'h0);

      // Loopback
      loopOn = 1'b1;
      regWrite("loop write", 1'b1, 32'hC3);
      tick(60);
      check("loop irqs", {30'b0, RxIrq, TxIrq}, 32'd3);
      regRead("loop status", 1'b0, 32'h03);
      regRead("loop data", 1'b1, 32'hC3);
      loopOn = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_slave.md
Name: uart_slave

Overview:
- Memory-mapped UART peripheral attached to bus slave port S5 of the shared bus.
- Consumes the slave-side bus signals and drives the top-level UartTX pin. It also samples the UartRX pin.
- Provides one-byte transmit and receive buffers, 8N1 framing, a status register, and two interrupt lines routed into the CPU IRQ bus.

Parameters:
- DIV_CNT, 260, system clocks per UART bit period (minimum 4). The bench uses 4.
- DIV_W, 9, width of the bit-period counter. Must satisfy 2^DIV_W > DIV_CNT.

Ports:
- clk  in  1  system clock
- reset_  in  1  synchronous active-low reset
- CS_  in  1  slave chip select, active low
- As_  in  1  address strobe, active low
- RW  in  1  1 = read, 0 = write
- Addr  in  30  word address; only Addr[0] decoded
- WrData  in  32  write data
- RdData  out  32  read data
- Rdy_  out  1  transfer ready, active low
- RxIrq  out  1  receive interrupt (mirrors STATUS.RxIntr)
- TxIrq  out  1  transmit interrupt (mirrors STATUS.TxIntr)
- UartRX  in  1  serial input, asynchronous
- UartTX  out  1  serial output

Behaviour:
Interface decisions:
- One clock. Reset is synchronous and active-low.
- Every register updates only on a posedge of clk. reset_==0 at an edge overrides all other activity, including mid-frame.

Reset values:
- RdData=0, Rdy_=1, UartTX=1, RxIrq=0, TxIrq=0.
- All STATUS bits 0, rx data register 0, both FSMs in IDLE.

Bus handshake:
- An access is accepted on an edge where CS_==0 and As_==0.
- The following cycle: Rdy_=0 for exactly one cycle. For a read, RdData also carries the data in that cycle.
- Every other cycle: Rdy_=1 and RdData=0.
- Latency is 1 cycle with no wait states. Back-to-back accesses give back-to-back Rdy_ pulses.

Register map (Addr[0]):
- 0 = STATUS
  - bit0 RxIntr (rw0)
  - bit1 TxIntr (rw0)
  - bit2 RxBusy (ro)
  - bit3 TxBusy (ro)
  - bit4 FrameErr (rw0)
  - bit5 Overrun (rw0)
  - other bits read 0.
  - A write loads bits 0, 1, 4, 5 from WrData. A hardware set on the same edge wins over the software write.
- 1 = DATA
  - Read returns {24'b0, rx_data}. Reading does not clear RxIntr.
  - Write while TxBusy=0: latch WrData[7:0], set TxBusy on the next edge, start the frame.
  - Write while TxBusy=1: ignored. Rdy_ still pulses.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: UartTX=1.
- START: UartTX=0 for DIV_CNT cycles.
- DATA: bits sent LSB first, DIV_CNT cycles each. A 3-bit index advances 0..7 and wraps only on leaving DATA.
- STOP: UartTX=1 for DIV_CNT cycles.
- Exiting STOP: TxBusy=0, TxIntr=1, return to IDLE.
- UartTX is registered. The first start-bit cycle appears 2 edges after the accepted DATA write.
- Total frame length is 10*DIV_CNT cycles.

RX path:
- UartRX passes through a 2-flop synchronizer (rx_s) before any use.

RX FSM (IDLE, START, DATA, STOP, WAIT_HIGH):
- IDLE: rx_s==0 → START, RxBusy=1, counter cleared.
- START: at count DIV_CNT/2:
  - rx_s==1: glitch; return to IDLE, RxBusy=0, no flags set.
  - otherwise: enter DATA.
- DATA: sample rx_s every DIV_CNT cycles (bit centres) into a shift register, LSB first, 8 samples.
- STOP: sample after another DIV_CNT cycles.
  - rx_s==1: rx_data ← shift register, RxIntr=1. If RxIntr was already 1 beforehand, also Overrun=1.
  - rx_s==0: FrameErr=1, rx_data unchanged; → WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE. This prevents a break condition from retriggering.
- RxBusy clears on leaving STOP (good stop) or on leaving WAIT_HIGH (bad stop).

Interrupts and TX/RX independence:
- RxIrq and TxIrq are the STATUS bits, not pulses. They stay high until software writes 0.
- TX and RX run fully independently, and simultaneous events in both are legal.

Test Plan:
- Reset: hold reset_=0 for 3 edges mid-TX-frame → UartTX=1, Rdy_=1, RdData=0, STATUS reads 0x00, TX restarts only on a new write.
- TX with DIV_CNT=4: write DATA=0x0000_00A5 →
  - Rdy_ low 1 cycle;
  - UartTX shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - TxIntr/TxIrq=1 and STATUS=0x02 after 40 cycles;
  - a write of 0 to STATUS clears it.
- TX busy: write 0x3C, then write 0xFF during the frame → the serialized byte is 0x3C only, and a second Rdy_ pulse is still seen.
- RX:
  - drive frame 0x5A on UartRX → RxIrq=1, DATA read=0x0000_005A, Rdy_ timing 1 cycle;
  - send a second frame 0x11 without clearing → Overrun=1, DATA=0x11.
- RX error:
  - a 1-cycle low glitch → no flags set;
  - a frame 0x33 with stop bit low held 20 cycles → FrameErr=1, rx_data unchanged, no retrigger until the line returns high.
- Loopback: tie UartTX to UartRX and write 0xC3 → both TxIntr and RxIntr set, STATUS=0x03, DATA read=0xC3.
